// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx byte arbiter.
package uart_arb_pkg;

  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 200_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
module uart_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index,
  output logic          any
);

  always_comb begin
    int unsigned c;
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!any && req[IW'(c)]) begin
        any   = 1'b1;
        index = IW'(c);
      end
    end
    if (any) gnt[index] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*8-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       arb_busy,
  output logic                       err_timeout
);

  localparam int unsigned IdW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic             start_q, start_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [IdW-1:0]   next_ptr;

  logic [N_REQ-1:0] pick_gnt;
  logic [IdW-1:0]   pick_idx;
  logic             pick_any;

  uart_rr_pick #(
    .N  (N_REQ),
    .IW (IdW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign next_ptr = IdW'(wrap_inc(32'(grant_q), N_REQ));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned WdW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYC - 1);

  logic [WdW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    start_d  = 1'b0;
    ready_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    wdog_d   = wdog_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          data_d  = req_data[{pick_idx, 3'b000} +: 8];
          ready_d = pick_gnt;
          state_d = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      WAIT_DONE: begin
        // tx_done wins over a coincident watchdog expiry.
        if (tx_done) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wdog_q == WdMax) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= 8'h00;
      start_q  <= 1'b0;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign grant_id  = grant_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb; expected grants are queued when requests are driven.
module tb_uart_tx_arb;

  localparam int unsigned NReq = 4;
  localparam int unsigned Tmo  = 50;

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NReq-1:0] req_valid;
  logic [NReq*8-1:0] req_data;
  logic [NReq-1:0] req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            arb_busy;
  logic            err_timeout;

  logic auto_done;
  logic auto_pulse;
  logic man_done;
  int   frame_len;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  assign tx_done = auto_pulse | man_done;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_REQ       (NReq),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!tx_start && n < budget) begin
      tick();
      n++;
    end
    check_eq("start_seen", {31'd0, tx_start}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (arb_busy && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_seen", {31'd0, arb_busy}, 32'd0);
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  task automatic do_reset();
    auto_done = 1'b0;
    man_done  = 1'b0;
    req_valid = '0;
    tx_busy   = 1'b0;
    rst       = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    check_eq({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, arb_busy}, 32'd0);
    check_eq({tag, "_gid"}, {30'd0, grant_id}, 32'd0);
    check_eq({tag, "_data"}, {24'd0, tx_data}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
  endtask

  // Scoreboard: every tx_start must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_start", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_data", {24'd0, tx_data}, {24'd0, e.data});
          check_eq("sb_gid", {30'd0, grant_id}, {30'd0, e.gid});
        end
      end
    end
  end

  // Frame responder; gap counts rising edges from the edge sampling tx_done to tx_start.
  initial begin
    int frm_cnt = 0;
    int gap     = 0;
    bit gap_on  = 1'b0;
    auto_pulse = 1'b0;
    forever begin
      tick();
      if (!auto_done) begin
        auto_pulse = 1'b0;
        frm_cnt    = 0;
        gap_on     = 1'b0;
      end else begin
        if (auto_pulse) begin
          auto_pulse = 1'b0;
          gap_on     = 1'b1;
          gap        = 0;
        end else if (gap_on) begin
          gap++;
        end
        if (tx_start) begin
          if (gap_on) check_eq("done_to_start", gap, 32'd2);
          gap_on  = 1'b0;
          frm_cnt = frame_len;
        end else if (frm_cnt == 1) begin
          auto_pulse = 1'b1;
          frm_cnt    = 0;
        end else if (frm_cnt > 1) begin
          frm_cnt--;
        end
      end
    end
  end

  initial begin
    int n;
    int err_seen;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    man_done  = 1'b0;
    auto_done = 1'b0;
    frame_len = 6;
    repeat (2) tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // Single request from requester 2.
    auto_done = 1'b1;
    req_data  = 32'h0041_0000;
    req_valid = 4'b0100;
    exp_q.push_back('{gid: 2'd2, data: 8'h41});
    tick();
    check_eq("single_ready", {28'd0, req_ready}, 32'h4);
    check_eq("single_start_early", {31'd0, tx_start}, 32'd0);
    req_valid = '0;
    tick();
    check_eq("single_ready_off", {28'd0, req_ready}, 32'd0);
    check_eq("single_start", {31'd0, tx_start}, 32'd1);
    check_eq("single_gid", {30'd0, grant_id}, 32'd2);
    wait_idle(40);

    // All requesters busy: strict rotation starting at 0.
    do_reset();
    auto_done = 1'b1;
    req_data  = 32'h3332_3130;
    for (int i = 0; i < 5; i++) exp_q.push_back('{gid: 2'(i % 4), data: 8'(8'h30 + (i % 4))});
    req_valid = 4'b1111;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check_eq("rr_drain", exp_q.size(), 32'd0);
    req_valid = '0;
    wait_idle(40);

    // tx_busy holds off tx_start while in START.
    do_reset();
    tx_busy   = 1'b1;
    req_data  = 32'h0000_005A;
    req_valid = 4'b0001;
    exp_q.push_back('{gid: 2'd0, data: 8'h5A});
    tick();
    check_eq("busy_ready", {28'd0, req_ready}, 32'h1);
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_start) n++;
    end
    check_eq("busy_holdoff", n, 32'd0);
    check_eq("busy_in_start", {31'd0, arb_busy}, 32'd1);
    tx_busy = 1'b0;
    tick();
    check_eq("busy_release_start", {31'd0, tx_start}, 32'd1);
    pulse_done();
    wait_idle(10);

    // Timeout: tx_done never arrives.
    do_reset();
    req_data  = 32'h0000_7700;
    req_valid = 4'b0010;
    exp_q.push_back('{gid: 2'd1, data: 8'h77});
    tick();
    req_valid = '0;
    wait_start(10);
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    while (!err_timeout && n < 100) begin
      tick();
      n++;
    end
    check_eq("tmo_latency", n, Tmo);
    check_eq("tmo_idle", {31'd0, arb_busy}, 32'd0);
    tick();
    check_eq("tmo_pulse_len", {31'd0, err_timeout}, 32'd0);
    check_eq("tmo_idle_next", {31'd0, arb_busy}, 32'd0);
`else
    err_seen = 0;
    repeat (Tmo + 10) begin
      tick();
      if (err_timeout) err_seen++;
    end
    check_eq("nowd_err", err_seen, 32'd0);
    check_eq("nowd_busy", {31'd0, arb_busy}, 32'd1);
    pulse_done();
    wait_idle(10);
`endif

    // Mid-frame reset, then lowest valid index wins.
    do_reset();
    req_data  = 32'h0000_0011;
    req_valid = 4'b0001;
    exp_q.push_back('{gid: 2'd0, data: 8'h11});
    tick();
    req_valid = '0;
    wait_start(10);
    repeat (3) tick();
    check_eq("mid_busy_before", {31'd0, arb_busy}, 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    tick();
    rst       = 1'b1;
    req_data  = 32'hDD00_BB00;
    req_valid = 4'b1010;
    exp_q.push_back('{gid: 2'd1, data: 8'hBB});
    tick();
    check_eq("mid_ready", {28'd0, req_ready}, 32'h2);
    req_valid = '0;
    wait_start(10);
    check_eq("mid_gid", {30'd0, grant_id}, 32'd1);
    pulse_done();
    wait_idle(10);

    // tx_done coincides with watchdog expiry: done wins.
    do_reset();
    req_data  = 32'h6600_0000;
    req_valid = 4'b1000;
    exp_q.push_back('{gid: 2'd3, data: 8'h66});
    tick();
    req_valid = '0;
    wait_start(10);
    err_seen = 0;
    repeat (Tmo - 1) begin
      tick();
      if (err_timeout) err_seen++;
    end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    if (err_timeout) err_seen++;
    check_eq("coll_idle", {31'd0, arb_busy}, 32'd0);
    repeat (3) begin
      tick();
      if (err_timeout) err_seen++;
    end
    check_eq("coll_no_err", err_seen, 32'd0);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001 The block SHALL have parameter N_REQ, default 4: number of byte requesters sharing one uart_tx (range 2..8).
- REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 200_000: clock cycles allowed between tx_start and tx_done (about 2 frames at 9600 baud, 100 MHz).
- REQ-003 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-005 The block SHALL have port req_valid, input, N_REQ bits: requester i holds a byte pending.
- REQ-006 The block SHALL have port req_data, input, N_REQ*8 bits: byte of requester i at bits [8i+7:8i].
- REQ-007 The block SHALL have port req_ready, output, N_REQ bits: one-cycle accept pulse, one-hot.
- REQ-008 The block SHALL have port tx_start, output, 1 bit: one-cycle start pulse to uart_tx.
- REQ-009 The block SHALL have port tx_data, output, 8 bits: byte presented to uart_tx, stable from tx_start until tx_done.
- REQ-010 The block SHALL have port tx_busy, input, 1 bit: uart_tx frame in progress.
- REQ-011 The block SHALL have port tx_done, input, 1 bit: one-cycle uart_tx frame-complete pulse.
- REQ-012 The block SHALL have port grant_id, output, clog2(N_REQ) bits: index of the requester currently owning the transmitter.
- REQ-013 The block SHALL have port arb_busy, output, 1 bit: high in any state other than IDLE.
- REQ-014 The block SHALL have port err_timeout, output, 1 bit: one-cycle pulse on watchdog expiry (only when UART_ARB_TIMEOUT_EN is defined).

Function
- REQ-015 The FSM SHALL have exactly three states: IDLE, START and WAIT_DONE.
- REQ-016 In IDLE with any req_valid bit set, the block SHALL select a requester round-robin from rr_ptr upward, modulo N_REQ.
- REQ-017 On selection, the block SHALL latch the selected byte into tx_data, set grant_id, pulse that requester's req_ready bit for one cycle and move to START.
- REQ-018 A requester SHALL sample req_ready and may present a new byte from the next cycle; the block SHALL NOT accept from requester i again until the current frame ends.
- REQ-019 In START, the block SHALL wait while tx_busy=1; with tx_busy=0 it SHALL pulse tx_start for one cycle and move to WAIT_DONE.
- REQ-020 In WAIT_DONE on tx_done, the block SHALL set rr_ptr to (grant_id+1) mod N_REQ and return to IDLE.
- REQ-021 The block SHALL sit exactly one cycle in IDLE between frames; tx_done-to-next-tx_start latency SHALL be 2 cycles when a request is pending and tx_busy=0.
- REQ-022 In START and WAIT_DONE, the block SHALL ignore req_valid.
- REQ-023 In IDLE, the block SHALL ignore tx_done.
- REQ-024 A requester deasserting req_valid before acceptance SHALL be skipped without side effect.
- REQ-025 With all req_valid bits set continuously, grants SHALL follow the order 0,1,...,N_REQ-1,0 with no starvation.

Reset
- REQ-026 Asserting rst low SHALL immediately force: state=IDLE, rr_ptr=0, grant_id=0, tx_data=8'h00, tx_start=0, req_ready=0, arb_busy=0, err_timeout=0, watchdog=0.
- REQ-027 Reset asserted mid-frame SHALL abandon the frame; after reset the first grant SHALL go to the lowest-index valid requester.

Configuration
- REQ-028 With macro UART_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_DONE, cleared on entry to WAIT_DONE.
- REQ-029 With UART_ARB_TIMEOUT_EN defined, when the watchdog reaches TIMEOUT_CYC-1 without tx_done, the block SHALL pulse err_timeout, advance rr_ptr as in REQ-020 and return to IDLE.
- REQ-030 With UART_ARB_TIMEOUT_EN defined, tx_done and expiry in the same cycle SHALL be treated as tx_done, with no error pulse.
- REQ-031 Without UART_ARB_TIMEOUT_EN, the block SHALL have no watchdog counter, err_timeout SHALL be tied 0, and WAIT_DONE SHALL wait indefinitely.

Structure
- REQ-032 Package uart_arb_pkg SHALL hold the state enum (IDLE/START/WAIT_DONE) and default constants N_REQ_DEF=4 and TIMEOUT_DEF=200_000.
- REQ-033 Combinational round-robin selection SHALL live in sub-module uart_rr_pick: inputs req, ptr; outputs one-hot gnt, index, any.

Verification
- REQ-034 Scenario single request: req_valid=4'b0100, byte 8'h41 -> req_ready=4'b0100 for 1 cycle, tx_start 1 cycle later with tx_data=8'h41, grant_id=2.
- REQ-035 Scenario all busy: req_valid=4'b1111 held, bytes 8'h30..8'h33, tx_done modelled at 1 frame -> tx_data sequence 8'h30,31,32,33,30.
- REQ-036 Scenario tx_busy: tx_busy=1 held 5 cycles while in START -> tx_start held off until the first cycle with tx_busy=0.
- REQ-037 Scenario timeout: TIMEOUT_CYC=50, tx_done never pulsed -> err_timeout pulse exactly 50 cycles after tx_start, arb_busy=0 next cycle; without the macro -> arb_busy stays 1.
- REQ-038 Scenario mid-frame reset: rst low during WAIT_DONE -> all outputs at reset values within the same timestep; after release, req_valid=4'b1010 -> grant_id=1.
- REQ-039 Scenario collision: tx_done on the same cycle as watchdog expiry -> no err_timeout, normal return to IDLE.
